// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - ID->EX pipeline register bundle
interface id_stage_if;
  logic        valid_ex;
  logic [31:0] inst_ex;
  logic [31:2] pc_ex;
  logic [31:0] rs1_data_ex;
  logic [31:0] rs2_data_ex;
  logic [31:0] imm_ex;
  logic [4:0]  rd_adr_ex;
  logic        wbk_en_ex;
  logic        cmd_ld_ex;
  logic        cmd_st_ex;

  modport master (
    output valid_ex, inst_ex, pc_ex, rs1_data_ex, rs2_data_ex,
           imm_ex, rd_adr_ex, wbk_en_ex, cmd_ld_ex, cmd_st_ex
  );

  modport slave (
    input valid_ex, inst_ex, pc_ex, rs1_data_ex, rs2_data_ex,
          imm_ex, rd_adr_ex, wbk_en_ex, cmd_ld_ex, cmd_st_ex
  );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage: regfile, immediate, load-use hazard, ID->EX register
// Optional macro ID_WB_BYPASS_EN: same-cycle writeback data is forwarded to the read ports.
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_id,
  input  logic [31:2] pc_id,
  input  logic        jmp_flush,
  input  logic        rst_pipe,
  input  logic        stall,
  input  logic        wbk_en,
  input  logic [4:0]  wbk_adr,
  input  logic [31:0] wbk_data,
  output logic        stall_ld,
  output logic        stall_ld_ex,
  id_stage_if.master  ex
);

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_OPIMM  = 7'b001_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_SYSTEM = 7'b111_0011;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:2] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wbk_en;
    logic        cmd_ld;
    logic        cmd_st;
  } ex_t;

  localparam ex_t EX_BUBBLE = '{
    valid:    1'b0,
    inst:     NOP_INST,
    pc:       30'd0,
    rs1_data: 32'd0,
    rs2_data: 32'd0,
    imm:      32'd0,
    rd:       5'd0,
    wbk_en:   1'b0,
    cmd_ld:   1'b0,
    cmd_st:   1'b0
  };

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [6:0]  opcode;
  logic        sgn;

  assign rs1    = inst_id[19:15];
  assign rs2    = inst_id[24:20];
  assign rd     = inst_id[11:7];
  assign opcode = inst_id[6:0];
  assign sgn    = inst_id[31];

  // Register file: x0 is never written and is forced to zero on read.
  logic [31:0] rf [32];
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  always_ff @(posedge clk) begin
    if (wbk_en && (wbk_adr != 5'd0)) begin
      rf[wbk_adr] <= wbk_data;
    end
  end

  always_comb begin
    rs1_data = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    rs2_data = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
`ifdef ID_WB_BYPASS_EN
    if (wbk_en && (wbk_adr != 5'd0) && (wbk_adr == rs1)) rs1_data = wbk_data;
    if (wbk_en && (wbk_adr != 5'd0) && (wbk_adr == rs2)) rs2_data = wbk_data;
`endif
  end

  logic [31:0] imm;
  logic        rs1_used;
  logic        rs2_used;
  logic        writes_rd;
  logic        is_ld;
  logic        is_st;

  always_comb begin
    imm       = 32'd0;
    rs1_used  = 1'b1;
    rs2_used  = 1'b0;
    writes_rd = 1'b0;
    is_ld     = 1'b0;
    is_st     = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        imm       = {{20{sgn}}, inst_id[31:20]};
        writes_rd = 1'b1;
        is_ld     = 1'b1;
      end
      OPC_OPIMM, OPC_JALR, OPC_SYSTEM: begin
        imm       = {{20{sgn}}, inst_id[31:20]};
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        imm      = {{20{sgn}}, inst_id[31:25], inst_id[11:7]};
        rs2_used = 1'b1;
        is_st    = 1'b1;
      end
      OPC_BRANCH: begin
        imm      = {{19{sgn}}, sgn, inst_id[7], inst_id[30:25], inst_id[11:8], 1'b0};
        rs2_used = 1'b1;
      end
      OPC_OP: begin
        rs2_used  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm       = {inst_id[31:12], 12'h000};
        rs1_used  = 1'b0;
        writes_rd = 1'b1;
      end
      OPC_JAL: begin
        imm       = {{11{sgn}}, sgn, inst_id[19:12], inst_id[20], inst_id[30:21], 1'b0};
        rs1_used  = 1'b0;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  ex_t ex_q;
  ex_t ex_dec;
  logic run;

  always_comb begin
    ex_dec          = EX_BUBBLE;
    ex_dec.valid    = 1'b1;
    ex_dec.inst     = inst_id;
    ex_dec.pc       = pc_id;
    ex_dec.rs1_data = rs1_data;
    ex_dec.rs2_data = rs2_data;
    ex_dec.imm      = imm;
    ex_dec.rd       = rd;
    ex_dec.wbk_en   = writes_rd && (rd != 5'd0);
    ex_dec.cmd_ld   = is_ld;
    ex_dec.cmd_st   = is_st;
  end

  assign stall_ld = ex_q.valid && ex_q.cmd_ld && (ex_q.rd != 5'd0) &&
                    ((rs1_used && (rs1 == ex_q.rd)) || (rs2_used && (rs2 == ex_q.rd)));

  // run stays low for the first edge after reset so that edge always issues a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= EX_BUBBLE;
      run         <= 1'b0;
      stall_ld_ex <= 1'b0;
    end else begin
      run <= 1'b1;
      if (rst_pipe) begin
        stall_ld_ex <= 1'b0;
      end else if (!stall) begin
        stall_ld_ex <= stall_ld;
      end
      if (rst_pipe || jmp_flush || !run) begin
        ex_q <= EX_BUBBLE;
      end else if (stall) begin
        ex_q <= ex_q;
      end else if (stall_ld) begin
        ex_q <= EX_BUBBLE;
      end else begin
        ex_q <= ex_dec;
      end
    end
  end

  assign ex.valid_ex    = ex_q.valid;
  assign ex.inst_ex     = ex_q.inst;
  assign ex.pc_ex       = ex_q.pc;
  assign ex.rs1_data_ex = ex_q.rs1_data;
  assign ex.rs2_data_ex = ex_q.rs2_data;
  assign ex.imm_ex      = ex_q.imm;
  assign ex.rd_adr_ex   = ex_q.rd;
  assign ex.wbk_en_ex   = ex_q.wbk_en;
  assign ex.cmd_ld_ex   = ex_q.cmd_ld;
  assign ex.cmd_st_ex   = ex_q.cmd_st;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with randomized RV32I stimulus
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_id;
  logic [31:2] pc_id;
  logic        jmp_flush, rst_pipe, stall;
  logic        wbk_en;
  logic [4:0]  wbk_adr;
  logic [31:0] wbk_data;
  logic        stall_ld, stall_ld_ex;

  id_stage_if ex_if ();

  id_stage #(.NOP_INST(32'h0000_0013)) dut (
    .clk(clk), .rst_n(rst_n), .inst_id(inst_id), .pc_id(pc_id),
    .jmp_flush(jmp_flush), .rst_pipe(rst_pipe), .stall(stall),
    .wbk_en(wbk_en), .wbk_adr(wbk_adr), .wbk_data(wbk_data),
    .stall_ld(stall_ld), .stall_ld_ex(stall_ld_ex), .ex(ex_if.master)
  );

  always #5 clk = ~clk;

  localparam bit [6:0] LOAD = 7'h03, STORE = 7'h23, BRANCH = 7'h63, JALR = 7'h67, JAL = 7'h6F;
  localparam bit [6:0] OPIMM = 7'h13, OP = 7'h33, LUI = 7'h37, AUIPC = 7'h17, SYSTEM = 7'h73;

  typedef struct {
    bit        valid;
    bit [31:0] inst;
    bit [29:0] pc;
    bit [31:0] r1, r2, imm;
    bit [4:0]  rd;
    bit        wen, ld, st, sldx, sld;
  } exp_t;

  exp_t      sb_q[$];
  exp_t      m;
  bit        m_run;
  bit [31:0] m_rf[32];
  int        n_tests = 0;
  int        n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t bubble();
    exp_t b = '{default: 0};
    b.inst = 32'h0000_0013;
    return b;
  endfunction

  function automatic bit [31:0] m_imm(input bit [31:0] i);
    int s = $signed(i);
    case (i[6:0])
      LOAD, OPIMM, JALR, SYSTEM: return s >>> 20;
      STORE:      return ((s >>> 25) << 5) | int'(i[11:7]);
      BRANCH:     return ((s >>> 31) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1);
      LUI, AUIPC: return i & 32'hFFFF_F000;
      JAL:        return ((s >>> 31) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1);
      default:    return 0;
    endcase
  endfunction

  function automatic bit [31:0] m_read(input bit [4:0] r, input bit we, input bit [4:0] wa, input bit [31:0] wd);
    if (r == 0) return 0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == r) return wd;
`endif
    return m_rf[r];
  endfunction

  // Apply one cycle of inputs, queue what the DUT should show now, then advance the model.
  task automatic drive(input bit rn, input bit [31:0] inst, input bit [29:0] pc, input bit fl,
                       input bit rp, input bit st, input bit we, input bit [4:0] wa, input bit [31:0] wd);
    exp_t item, nx, ld_v;
    bit [6:0] op;
    bit u1, u2, sld;
    @(negedge clk);
    rst_n = rn; inst_id = inst; pc_id = pc; jmp_flush = fl; rst_pipe = rp; stall = st;
    wbk_en = we; wbk_adr = wa; wbk_data = wd;
    if (!rn) begin
      m = bubble();
      m_run = 0;
    end
    op  = inst[6:0];
    u1  = !(op inside {LUI, AUIPC, JAL});
    u2  = op inside {OP, STORE, BRANCH};
    sld = m.valid && m.ld && m.rd != 0 &&
          ((u1 && inst[19:15] == m.rd) || (u2 && inst[24:20] == m.rd));
    item = m;
    item.sld = sld;
    sb_q.push_back(item);
    if (rn) begin
      ld_v = bubble();
      ld_v.valid = 1; ld_v.inst = inst; ld_v.pc = pc;
      ld_v.r1 = m_read(inst[19:15], we, wa, wd);
      ld_v.r2 = m_read(inst[24:20], we, wa, wd);
      ld_v.imm = m_imm(inst);
      ld_v.rd = inst[11:7];
      ld_v.wen = (op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, SYSTEM}) && inst[11:7] != 0;
      ld_v.ld = (op == LOAD);
      ld_v.st = (op == STORE);
      nx = m;
      if (rp) nx.sldx = 0;
      else if (!st) nx.sldx = sld;
      if (rp || fl || !m_run || (!st && sld)) begin
        ld_v = bubble();
        ld_v.sldx = nx.sldx;
        nx = ld_v;
      end else if (!st) begin
        ld_v.sldx = nx.sldx;
        nx = ld_v;
      end
      m = nx;
      m_run = 1;
    end
    if (we && wa != 0) m_rf[wa] = wd;
  endtask

  task automatic run_cyc(input bit [31:0] inst, input bit we = 0, input bit [4:0] wa = 0, input bit [31:0] wd = 0);
    drive(1, inst, 30'h100, 0, 0, 0, we, wa, wd);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("valid_ex", 32'(ex_if.valid_ex), 32'(e.valid));
        chk("inst_ex", ex_if.inst_ex, e.inst);
        chk("pc_ex", 32'(ex_if.pc_ex), 32'(e.pc));
        chk("rs1_data_ex", ex_if.rs1_data_ex, e.r1);
        chk("rs2_data_ex", ex_if.rs2_data_ex, e.r2);
        chk("imm_ex", ex_if.imm_ex, e.imm);
        chk("rd_adr_ex", 32'(ex_if.rd_adr_ex), 32'(e.rd));
        chk("wbk_en_ex", 32'(ex_if.wbk_en_ex), 32'(e.wen));
        chk("cmd_ld_ex", 32'(ex_if.cmd_ld_ex), 32'(e.ld));
        chk("cmd_st_ex", 32'(ex_if.cmd_st_ex), 32'(e.st));
        chk("stall_ld_ex", 32'(stall_ld_ex), 32'(e.sldx));
        chk("stall_ld", 32'(stall_ld), 32'(e.sld));
      end
    end
  end

  function automatic bit [31:0] rand_inst();
    bit [6:0] ops[11] = '{LOAD, STORE, BRANCH, JALR, JAL, OPIMM, OP, LUI, AUIPC, SYSTEM, 7'h7F};
    bit [31:0] i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 10)];
    i[11:7]  = 5'($urandom_range(0, 7));
    i[19:15] = 5'($urandom_range(0, 7));
    i[24:20] = 5'($urandom_range(0, 7));
    return i;
  endfunction

  initial begin : stim
    bit [31:0] exp7;
    rst_n = 0; inst_id = 0; pc_id = 0; jmp_flush = 0; rst_pipe = 0; stall = 0;
    wbk_en = 0; wbk_adr = 0; wbk_data = 0;
    m = bubble();
    m_run = 0;

    repeat (3) drive(0, 32'h0002_8093, 30'h55, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("reset valid_ex", 32'(ex_if.valid_ex), 0);
    chk("reset inst_ex", ex_if.inst_ex, 32'h0000_0013);
    chk("reset stall_ld_ex", 32'(stall_ld_ex), 0);

    drive(1, 32'h0002_8093, 30'h55, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("first edge bubble", 32'(ex_if.valid_ex), 0);

    for (int r = 1; r < 32; r++) run_cyc(32'h0000_0013, 1, 5'(r), $urandom);

    run_cyc(32'h0000_0013, 1, 5, 32'h1234_5678);
    run_cyc(32'h0002_8093);
    after_edge();
    chk("addi valid_ex", 32'(ex_if.valid_ex), 1);
    chk("addi rs1_data_ex", ex_if.rs1_data_ex, 32'h1234_5678);
    chk("addi imm_ex", ex_if.imm_ex, 0);
    chk("addi rd_adr_ex", 32'(ex_if.rd_adr_ex), 1);
    chk("addi wbk_en_ex", 32'(ex_if.wbk_en_ex), 1);

    run_cyc(32'hFFC0_0093);
    after_edge();
    chk("I-imm -4", ex_if.imm_ex, 32'hFFFF_FFFC);
    run_cyc(32'hFE00_0EE3);
    after_edge();
    chk("B-imm -4", ex_if.imm_ex, 32'hFFFF_FFFC);
    chk("beq wbk_en_ex", 32'(ex_if.wbk_en_ex), 0);

    run_cyc(32'h0000_2183);
    run_cyc(32'h0021_8233);
    #1;
    chk("load-use stall_ld", 32'(stall_ld), 1);
    after_edge();
    chk("load-use bubble", 32'(ex_if.valid_ex), 0);
    chk("load-use stall_ld_ex", 32'(stall_ld_ex), 1);
    run_cyc(32'h0021_8233);
    after_edge();
    chk("add issued", 32'(ex_if.valid_ex), 1);
    chk("add inst_ex", ex_if.inst_ex, 32'h0021_8233);

    drive(1, 32'h0002_8093, 30'h40, 1, 0, 0, 0, 0, 0);
    after_edge();
    chk("flush valid_ex", 32'(ex_if.valid_ex), 0);
    chk("flush inst_ex", ex_if.inst_ex, 32'h0000_0013);
    run_cyc(32'h0002_8093);
    repeat (3) begin
      drive(1, 32'hFFC0_0093, 30'h41, 0, 0, 1, 0, 0, 0);
      after_edge();
      chk("stall hold inst_ex", ex_if.inst_ex, 32'h0002_8093);
      chk("stall hold rs1_data_ex", ex_if.rs1_data_ex, 32'h1234_5678);
    end

    run_cyc(32'h0000_0013, 1, 7, 32'h0BAD_F00D);
    run_cyc(32'h0003_8093, 1, 7, 32'hA5A5_A5A5);
    after_edge();
`ifdef ID_WB_BYPASS_EN
    exp7 = 32'hA5A5_A5A5;
`else
    exp7 = 32'h0BAD_F00D;
`endif
    chk("same-cycle x7 read", ex_if.rs1_data_ex, exp7);
    run_cyc(32'h0003_8093);
    after_edge();
    chk("x7 after write", ex_if.rs1_data_ex, 32'hA5A5_A5A5);
    run_cyc(32'h0000_0093, 1, 0, 32'hFFFF_FFFF);
    run_cyc(32'h0000_0093);
    after_edge();
    chk("x0 stays zero", ex_if.rs1_data_ex, 0);

    drive(0, 32'h0002_8093, 30'h7, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h0002_8093, 30'h7, 0, 0, 0, 0, 0, 0);
    after_edge();
    chk("reset release bubble", 32'(ex_if.valid_ex), 0);

    for (int n = 0; n < 1500; n++) begin
      drive(($urandom % 250) != 0, rand_inst(), 30'($urandom),
            ($urandom % 10) == 0, ($urandom % 25) == 0, ($urandom % 8) == 0,
            1'($urandom), 5'($urandom_range(0, 7)), $urandom);
    end

    repeat (2) run_cyc(32'h0000_0013);
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    #5;
    if (sb_q.size() != 0) chk("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have parameter NOP_INST, default 32'h0000_0013, the instruction word held in inst_ex while no instruction is valid.
REQ-002 SHALL have ports: clk input 1 clock; rst_n input 1 reset, asynchronous, active-low.
REQ-003 SHALL have ports: inst_id input 32 instruction from IF; pc_id input [31:2] its PC.
REQ-004 SHALL have ports: jmp_flush input 1 jump/trap taken in EX; rst_pipe input 1 pipeline reset; stall input 1 global hold.
REQ-005 SHALL have ports: wbk_en input 1, wbk_adr input 5, wbk_data input 32: register write from writeback.
REQ-006 SHALL have ports: stall_ld output 1 load-use hazard; stall_ld_ex output 1 stall_ld delayed one cycle.
REQ-007 SHALL have ports to EX, all registered: valid_ex 1; inst_ex 32; pc_ex [31:2]; rs1_data_ex 32; rs2_data_ex 32; imm_ex 32; rd_adr_ex 5; wbk_en_ex 1; cmd_ld_ex 1; cmd_st_ex 1.

Function
REQ-008 SHALL contain a 32x32 register file, 2 async read ports, 1 sync write port; x0 reads 0 and ignores writes.
REQ-009 SHALL decode rs1=inst_id[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0].
REQ-010 SHALL form imm by opcode: I (load, OP-IMM, JALR, SYSTEM) sign-ext [31:20]; S {[31:25],[11:7]}; B {[31],[7],[30:25],[11:8],0}; U {[31:12],12'h0}; J {[31],[19:12],[20],[30:21],0}; otherwise 0.
REQ-011 SHALL set rs1_used for all opcodes except LUI, AUIPC, JAL; rs2_used only for OP, STORE, BRANCH.
REQ-012 SHALL set wbk_en decode for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM when rd != 0.
REQ-013 SHALL assert stall_ld combinationally when valid_ex & cmd_ld_ex & rd_adr_ex != 0 & ((rs1_used & rs1==rd_adr_ex) | (rs2_used & rs2==rd_adr_ex)).
REQ-014 SHALL update the ID->EX register each clock with priority: rst_pipe or jmp_flush -> bubble; stall -> hold all; stall_ld -> bubble; else load decoded instruction with valid_ex=1.
REQ-015 Bubble SHALL mean valid_ex=0, wbk_en_ex=0, cmd_ld_ex=0, cmd_st_ex=0, inst_ex=NOP_INST; other fields don't-care but deterministic (zero).
REQ-016 SHALL register stall_ld into stall_ld_ex every cycle unless stall is high (hold); rst_pipe clears it.
REQ-017 Latency ID->EX SHALL be exactly one cycle; a stall_ld of N consecutive cycles SHALL insert N bubbles.
REQ-018 jmp_flush with stall_ld simultaneously SHALL produce a bubble and no hazard-related hold beyond that cycle.
REQ-019 Register writes SHALL occur whenever wbk_en & wbk_adr != 0, independent of stall, flush and rst_pipe.

Reset
REQ-020 On rst_n low all ID->EX outputs SHALL take bubble values (inst_ex=NOP_INST, pc_ex=0, data/imm/rd=0), stall_ld_ex=0.
REQ-021 Register file contents SHALL be reset to 0 only when ID_RF_RESET behaviour is not relied upon; x1..x31 are undefined after reset, x0 is 0.
REQ-022 Reset deassertion mid-operation SHALL yield a bubble on the first cycle regardless of inst_id.

Configuration
REQ-023 Macro ID_WB_BYPASS_EN: defined -> a read of register r in the same cycle as a write to r (r != 0) SHALL return wbk_data; undefined -> SHALL return the old contents.

Verification
REQ-024 Write x5=32'h1234_5678, then inst_id=32'h0002_8093 (addi x1,x5,0) -> next cycle valid_ex=1, rs1_data_ex=32'h1234_5678, imm_ex=0, rd_adr_ex=1, wbk_en_ex=1.
REQ-025 inst_id=32'hFFC0_0093 -> imm_ex=32'hFFFF_FFFC; inst_id=32'hFE00_0EE3 (beq, B-imm -4) -> imm_ex=32'hFFFF_FFFC, wbk_en_ex=0.
REQ-026 EX holds lw x3 (cmd_ld_ex=1, rd_adr_ex=3), inst_id=add x4,x3,x2 -> stall_ld=1, next valid_ex=0, following cycle stall_ld_ex=1 and add issued with valid_ex=1.
REQ-027 jmp_flush=1 with valid inst_id -> next valid_ex=0, inst_ex=32'h0000_0013; stall=1 for 3 cycles -> all EX outputs unchanged.
REQ-028 Same-cycle wbk_en=1, wbk_adr=7, wbk_data=32'hA5A5_A5A5 with inst_id reading x7 -> rs1_data_ex=32'hA5A5_A5A5 with ID_WB_BYPASS_EN, old x7 without; wbk_adr=0 -> x0 stays 0.
